// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu
// Description : Registered ALU. Bitwise, shift, byte-half and add/sub ops
//               complete one cycle after issue. Multiply, multiply-high,
//               divide and remainder run on a WIDTH-step shift engine behind
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_alu #(
   parameter int WIDTH   = 16,
   parameter int FLAGS_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               valid_in,
   input  logic [3:0]         op_code,
   input  logic [WIDTH-1:0]   source,
   input  logic [WIDTH-1:0]   destination,
   input  logic [FLAGS_W-1:0] flags,
   output logic               ready_out,
   output logic               valid_out,
   output logic [WIDTH-1:0]   result_out,
   output logic [FLAGS_W-1:0] flags_out,
   output logic               write_flags
);

   localparam int c_HALF  = WIDTH / 2;
   localparam int c_SH_W  = $clog2(WIDTH);
   localparam int c_CNT_W = $clog2(WIDTH);

   // Engine states
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_MUL  = 2'd1;
   localparam logic [1:0] c_DIV  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   // Operation codes
   localparam logic [3:0] c_OP_COPY  = 4'h0;
   localparam logic [3:0] c_OP_AND   = 4'h1;
   localparam logic [3:0] c_OP_OR    = 4'h2;
   localparam logic [3:0] c_OP_XOR   = 4'h3;
   localparam logic [3:0] c_OP_NOT   = 4'h4;
   localparam logic [3:0] c_OP_SHL   = 4'h5;
   localparam logic [3:0] c_OP_SHR   = 4'h6;
   localparam logic [3:0] c_OP_SWAP  = 4'h7;
   localparam logic [3:0] c_OP_HIGH  = 4'h8;
   localparam logic [3:0] c_OP_LOW   = 4'h9;
   localparam logic [3:0] c_OP_ADD   = 4'hA;
   localparam logic [3:0] c_OP_SUB   = 4'hB;
   localparam logic [3:0] c_OP_MUL   = 4'hC;
   localparam logic [3:0] c_OP_DIV   = 4'hD;
   localparam logic [3:0] c_OP_REM   = 4'hE;
   localparam logic [3:0] c_OP_MULHI = 4'hF;

   // Control / engine registers
   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_count;
   logic [3:0]         r_op;
   logic [FLAGS_W-1:5] r_flags_keep;
   // r_hi: multiply accumulator high half, or divide partial remainder.
   // r_lo: multiplier being shifted out / product low half, or dividend
   //       being shifted out / quotient being shifted in.
   logic [WIDTH:0]     r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opnd;

   // Output registers
   logic               r_valid;
   logic [WIDTH-1:0]   r_result;
   logic [FLAGS_W-1:0] r_flags_out;
   logic               r_write_flags;

   // Issue decode
   logic               w_accept;
   logic               w_is_multi;
   logic               w_is_divide;
   logic               w_div_zero;

   // Single-cycle datapath
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic               w_shamt_big;
   logic [WIDTH-1:0]   w_sc_result;
   logic               w_sc_carry;
   logic               w_sc_ovf;
   logic               w_sc_err;

   // Iterative engine datapath
   logic [WIDTH:0]     w_mul_hi_add;
   logic [WIDTH:0]     w_mul_hi_nxt;
   logic [WIDTH-1:0]   w_mul_lo_nxt;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_sub;
   logic               w_div_ge;
   logic [WIDTH:0]     w_div_hi_nxt;
   logic [WIDTH-1:0]   w_div_lo_nxt;
   logic [WIDTH:0]     w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic [WIDTH-1:0]   w_eng_result;
   logic               w_eng_carry;

   // The low five flag bits are always regenerated, so the incoming copy is dead.
   logic               w_unused;
   assign w_unused = ^flags[4:0];

   // Builds the outgoing flags word: pass-through upper bits plus fresh status.
   function automatic logic [FLAGS_W-1:0] f_pack(
      input logic [FLAGS_W-1:5] keep,
      input logic [WIDTH-1:0]   res,
      input logic               carry,
      input logic               ovf,
      input logic               err
   );
      f_pack = {keep, err, ovf, carry, res[WIDTH-1], (res == '0)};
   endfunction

   // DONE also accepts, so a new op may issue in the same cycle a result leaves.
   assign ready_out   = (r_state == c_IDLE) || (r_state == c_DONE);
   assign w_accept    = valid_in && ready_out;
   assign w_is_multi  = (op_code == c_OP_MUL) || (op_code == c_OP_DIV) ||
                        (op_code == c_OP_REM) || (op_code == c_OP_MULHI);
   assign w_is_divide = (op_code == c_OP_DIV) || (op_code == c_OP_REM);
   // A zero divisor short-circuits to a one-cycle error result.
   assign w_div_zero  = w_is_divide && (source == '0);

   assign valid_out   = r_valid;
   assign result_out  = r_result;
   assign flags_out   = r_flags_out;
   assign write_flags = r_write_flags;

   // Single-cycle result, carry and overflow from the live issue operands.
   always_comb begin
      w_sum       = {1'b0, destination} + {1'b0, source};
      w_diff      = {1'b0, destination} - {1'b0, source};
      w_shamt_big = (source >= WIDTH'(WIDTH));
      w_sc_result = '0;
      w_sc_carry  = 1'b0;
      w_sc_ovf    = 1'b0;
      w_sc_err    = 1'b0;
      case (op_code)
         c_OP_COPY: w_sc_result = source;
         c_OP_AND:  w_sc_result = destination & source;
         c_OP_OR:   w_sc_result = destination | source;
         c_OP_XOR:  w_sc_result = destination ^ source;
         c_OP_NOT:  w_sc_result = ~source;
         c_OP_SHL: begin
            if (w_shamt_big) w_sc_result = '0;
            else             w_sc_result = destination << source[c_SH_W-1:0];
         end
         c_OP_SHR: begin
            if (w_shamt_big)
               w_sc_result = flags[8] ? {WIDTH{destination[WIDTH-1]}} : '0;
            else if (flags[8])
               w_sc_result = WIDTH'($signed(destination) >>> source[c_SH_W-1:0]);
            else
               w_sc_result = destination >> source[c_SH_W-1:0];
         end
         c_OP_SWAP: w_sc_result = {source[c_HALF-1:0], source[WIDTH-1:c_HALF]};
         c_OP_HIGH: w_sc_result = {source[WIDTH-1:c_HALF], {c_HALF{1'b0}}};
         c_OP_LOW:  w_sc_result = {{(WIDTH-c_HALF){1'b0}}, source[c_HALF-1:0]};
         c_OP_ADD: begin
            w_sc_result = w_sum[WIDTH-1:0];
            w_sc_carry  = w_sum[WIDTH];
            w_sc_ovf    = (destination[WIDTH-1] == source[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != destination[WIDTH-1]);
         end
         c_OP_SUB: begin
            w_sc_result = w_diff[WIDTH-1:0];
            w_sc_carry  = w_diff[WIDTH];          // borrow: destination < source
            w_sc_ovf    = (destination[WIDTH-1] != source[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != destination[WIDTH-1]);
         end
         // Divide ops only reach this path with a zero divisor.
         c_OP_DIV: begin
            w_sc_result = '1;
            w_sc_err    = 1'b1;
         end
         c_OP_REM: begin
            w_sc_result = destination;
            w_sc_err    = 1'b1;
         end
         default: ;
      endcase
   end

   // One shift-add multiply step and one restoring-divide step per cycle.
   always_comb begin
      w_mul_hi_add = r_lo[0] ? (r_hi + {1'b0, r_opnd}) : r_hi;
      w_mul_hi_nxt = {1'b0, w_mul_hi_add[WIDTH:1]};
      w_mul_lo_nxt = {w_mul_hi_add[0], r_lo[WIDTH-1:1]};

      w_div_shift  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
      w_div_sub    = w_div_shift - {1'b0, r_opnd};
      w_div_ge     = (w_div_shift >= {1'b0, r_opnd});
      w_div_hi_nxt = w_div_ge ? w_div_sub : w_div_shift;
      w_div_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};

      w_hi_nxt     = (r_state == c_MUL) ? w_mul_hi_nxt : w_div_hi_nxt;
      w_lo_nxt     = (r_state == c_MUL) ? w_mul_lo_nxt : w_div_lo_nxt;
   end

   // Final engine result, taken from the step that completes the iteration.
   always_comb begin
      w_eng_result = '0;
      w_eng_carry  = 1'b0;
      case (r_op)
         c_OP_MUL: begin
            w_eng_result = w_mul_lo_nxt;
            w_eng_carry  = |w_mul_hi_nxt[WIDTH-1:0];
         end
         c_OP_MULHI: begin
            w_eng_result = w_mul_hi_nxt[WIDTH-1:0];
            w_eng_carry  = |w_mul_hi_nxt[WIDTH-1:0];
         end
         c_OP_DIV: w_eng_result = w_div_lo_nxt;
         c_OP_REM: w_eng_result = w_div_hi_nxt[WIDTH-1:0];
         default: ;
      endcase
   end

   // Issue handling, engine sequencing and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state       <= c_IDLE;
         r_count       <= '0;
         r_op          <= c_OP_COPY;
         r_flags_keep  <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_opnd        <= '0;
         r_valid       <= 1'b0;
         r_result      <= '0;
         r_flags_out   <= '0;
         r_write_flags <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            c_IDLE, c_DONE: begin
               r_state <= c_IDLE;
               if (w_accept) begin
                  r_op         <= op_code;
                  r_flags_keep <= flags[FLAGS_W-1:5];
                  if (w_is_multi && !w_div_zero) begin
                     r_state <= w_is_divide ? c_DIV : c_MUL;
                     r_count <= c_CNT_W'(WIDTH - 1);
                     r_hi    <= '0;
                     // Multiply shifts the multiplier (source) out of r_lo;
                     // divide shifts the dividend (destination) out of r_lo.
                     r_lo    <= w_is_divide ? destination : source;
                     r_opnd  <= w_is_divide ? source : destination;
                  end else begin
                     r_valid       <= 1'b1;
                     r_result      <= w_sc_result;
                     r_flags_out   <= f_pack(flags[FLAGS_W-1:5], w_sc_result,
                                             w_sc_carry, w_sc_ovf, w_sc_err);
                     r_write_flags <= (op_code != c_OP_COPY);
                  end
               end
            end
            c_MUL, c_DIV: begin
               r_hi    <= w_hi_nxt;
               r_lo    <= w_lo_nxt;
               r_count <= r_count - 1'b1;
               if (r_count == '0) begin
                  r_state       <= c_DONE;
                  r_valid       <= 1'b1;
                  r_result      <= w_eng_result;
                  r_flags_out   <= f_pack(r_flags_keep, w_eng_result,
                                          w_eng_carry, 1'b0, 1'b0);
                  r_write_flags <= 1'b1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_alu
// Description : Directed self-checking bench for iter_alu. A transaction-level
//               model predicts every result and its cycle; a compare process
//               checks the outputs each cycle, and literal checks pin the
//               model on hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

   localparam int W  = 16;
   localparam int FW = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          valid_in;
   logic [3:0]    op_code;
   logic [W-1:0]  source;
   logic [W-1:0]  destination;
   logic [FW-1:0] flags;
   logic          ready_out;
   logic          valid_out;
   logic [W-1:0]  result_out;
   logic [FW-1:0] flags_out;
   logic          write_flags;

   iter_alu #(.WIDTH(W), .FLAGS_W(FW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .valid_in    (valid_in),
      .op_code     (op_code),
      .source      (source),
      .destination (destination),
      .flags       (flags),
      .ready_out   (ready_out),
      .valid_out   (valid_out),
      .result_out  (result_out),
      .flags_out   (flags_out),
      .write_flags (write_flags)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [15:0] res;
      logic [15:0] fl;
      logic        wf;
   } exp_t;

   exp_t        q[$];
   int          cyc      = 0;
   int          busy_end = 0;
   bit          chk      = 1'b0;
   logic [15:0] held_r   = '0;
   logic [15:0] held_f   = '0;
   int          n_vec    = 0;
   int          n_err    = 0;
   int          acc_edge = 0;

   logic        s_valid, s_ready, s_wf;
   logic [15:0] s_res, s_flg;
   int          s_cyc;

   // Edge counter: after rising edge k, cyc == k.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference behaviour straight from the operation definitions.
   function automatic void model(input logic [3:0] op, input logic [15:0] d,
                                 input logic [15:0] s, input logic [15:0] f,
                                 output logic [15:0] r, output logic [15:0] fo,
                                 output bit multi);
      logic [31:0] prod, u;
      int          sd, ss, sr;
      logic        c, v, e;
      prod  = 32'(d) * 32'(s);
      sd    = int'($signed(d));
      ss    = int'($signed(s));
      c     = 1'b0;
      v     = 1'b0;
      e     = 1'b0;
      multi = 1'b0;
      r     = '0;
      case (op)
         4'h0: r = s;
         4'h1: r = d & s;
         4'h2: r = d | s;
         4'h3: r = d ^ s;
         4'h4: r = ~s;
         4'h5: r = (s >= 16) ? 16'h0000 : 16'(32'(d) << s);
         4'h6: begin
            if (f[8]) r = 16'(sd >>> ((s >= 16) ? 15 : int'(s)));
            else      r = (s >= 16) ? 16'h0000 : (d >> s);
         end
         4'h7: r = {s[7:0], s[15:8]};
         4'h8: r = {s[15:8], 8'h00};
         4'h9: r = {8'h00, s[7:0]};
         4'hA: begin
            u  = 32'(d) + 32'(s);
            r  = u[15:0];
            c  = (u > 32'h0000_FFFF);
            sr = sd + ss;
            v  = (sr > 32767) || (sr < -32768);
         end
         4'hB: begin
            r  = d - s;
            c  = (d < s);
            sr = sd - ss;
            v  = (sr > 32767) || (sr < -32768);
         end
         4'hC: begin r = prod[15:0];  c = (prod[31:16] != 0); multi = 1'b1; end
         4'hF: begin r = prod[31:16]; c = (prod[31:16] != 0); multi = 1'b1; end
         4'hD: begin
            if (s == 0) begin r = 16'hFFFF; e = 1'b1; end
            else        begin r = d / s;    multi = 1'b1; end
         end
         default: begin
            if (s == 0) begin r = d;     e = 1'b1; end
            else        begin r = d % s; multi = 1'b1; end
         end
      endcase
      fo = {f[15:5], e, v, c, r[15], (r == 16'h0000)};
   endfunction

   task automatic sample();
      @(negedge clock);
      s_valid = valid_out;
      s_ready = ready_out;
      s_res   = result_out;
      s_flg   = flags_out;
      s_wf    = write_flags;
      s_cyc   = cyc;
      #1;
   endtask

   // Drives one issue cycle; the model decides whether it is accepted.
   task automatic issue(input logic [3:0] op, input logic [15:0] d,
                        input logic [15:0] s, input logic [15:0] f);
      logic [15:0] r, fo;
      bit          multi;
      exp_t        e;
      op_code     = op;
      destination = d;
      source      = s;
      flags       = f;
      valid_in    = 1'b1;
      if (cyc >= busy_end) begin
         model(op, d, s, f, r, fo, multi);
         acc_edge = cyc + 1;
         e.due    = acc_edge + (multi ? W : 0);
         e.res    = r;
         e.fl     = fo;
         e.wf     = (op != 4'h0);
         q.push_back(e);
         if (multi) busy_end = acc_edge + W;
      end
      sample();
      valid_in = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int lat, output int low);
      int n;
      n   = 0;
      low = s_ready ? 0 : 1;
      while (!s_valid && n < budget) begin
         sample();
         n++;
         if (!s_ready) low++;
      end
      if (!s_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_valid: no valid_out within %0d cycles", budget);
      end
      lat = s_cyc - acc_edge;
   endtask

   task automatic do_reset(input int cycles);
      reset_n  = 1'b0;
      valid_in = 1'b0;
      q.delete();
      held_r   = '0;
      held_f   = '0;
      busy_end = cyc + 1;
      repeat (cycles) sample();
      reset_n  = 1'b1;
   endtask

   // Every-cycle comparison of all outputs against the model's prediction.
   always @(negedge clock) begin : b_cmp
      bit   due_now;
      exp_t e;
      if (chk) begin
         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         due_now = (q.size() > 0) && (q[0].due == cyc);
         check("valid_out", 32'(valid_out), 32'(due_now));
         if (due_now) begin
            e      = q.pop_front();
            held_r = e.res;
            held_f = e.fl;
            check("write_flags", 32'(write_flags), 32'(e.wf));
         end
         check("result_out", 32'(result_out), 32'(held_r));
         check("flags_out", 32'(flags_out), 32'(held_f));
         check("ready_out", 32'(ready_out), 32'(cyc >= busy_end));
      end
   end

   initial begin : b_watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : b_main
      int lat, low;
      reset_n     = 1'b0;
      valid_in    = 1'b0;
      op_code     = '0;
      source      = '0;
      destination = '0;
      flags       = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk = 1'b1;
      do_reset(2);
      check("reset ready_out", 32'(s_ready), 32'd1);
      check("reset valid_out", 32'(s_valid), 32'd0);
      check("reset result_out", 32'(s_res), 32'h0000);
      check("reset flags_out", 32'(s_flg), 32'h0000);
      check("reset write_flags", 32'(s_wf), 32'd0);

      // Back-to-back single-cycle ops
      issue(4'hA, 16'hFFFF, 16'h0001, 16'h0000);
      check("add valid", 32'(s_valid), 32'd1);
      check("add result", 32'(s_res), 32'h0000);
      check("add flags", 32'(s_flg), 32'h0005);      // zero + carry
      issue(4'hB, 16'h0003, 16'h0005, 16'h0000);
      check("sub valid", 32'(s_valid), 32'd1);
      check("sub result", 32'(s_res), 32'hFFFE);
      check("sub flags", 32'(s_flg), 32'h0006);      // negative + borrow
      issue(4'hA, 16'h7FFF, 16'h0001, 16'hA51F);
      check("add ovf result", 32'(s_res), 32'h8000);
      check("add ovf flags", 32'(s_flg), 32'hA50A);  // pass-through + ovf + neg
      issue(4'h7, 16'h0000, 16'h1234, 16'h0000);
      check("swap result", 32'(s_res), 32'h3412);
      issue(4'h8, 16'h0000, 16'h1234, 16'h0000);
      check("high result", 32'(s_res), 32'h1200);
      issue(4'h9, 16'h0000, 16'h1234, 16'h0000);
      check("low result", 32'(s_res), 32'h0034);
      issue(4'h1, 16'hF0F0, 16'h3C3C, 16'h0000);
      issue(4'h2, 16'hF0F0, 16'h3C3C, 16'h0000);
      issue(4'h3, 16'hF0F0, 16'h3C3C, 16'h0000);
      issue(4'h4, 16'h0000, 16'h00FF, 16'h0000);
      check("not result", 32'(s_res), 32'hFF00);

      // Multiply low/high; F issues in C's DONE cycle
      issue(4'hC, 16'h1234, 16'h5678, 16'h0000);
      wait_valid(40, lat, low);
      check("mul latency", 32'(lat), 32'd16);
      check("mul ready low cycles", 32'(low), 32'd16);
      check("mul result", 32'(s_res), 32'h0060);
      check("mul flags", 32'(s_flg), 32'h0004);
      check("mul write_flags", 32'(s_wf), 32'd1);
      issue(4'hF, 16'h1234, 16'h5678, 16'h0000);
      wait_valid(40, lat, low);
      check("mulhi latency", 32'(lat), 32'd16);
      check("mulhi ready low cycles", 32'(low), 32'd16);
      check("mulhi result", 32'(s_res), 32'h0626);
      check("mulhi flags", 32'(s_flg), 32'h0004);

      // Divide / remainder with ignored issues while busy
      issue(4'hD, 16'h0064, 16'h0007, 16'h0000);
      issue(4'hA, 16'h0001, 16'h0001, 16'h0000);
      issue(4'hC, 16'h00FF, 16'h00FF, 16'h0000);
      wait_valid(40, lat, low);
      check("div latency", 32'(lat), 32'd16);
      check("div result", 32'(s_res), 32'h000E);
      issue(4'hE, 16'h0064, 16'h0007, 16'h0100);
      issue(4'h5, 16'h0001, 16'h0001, 16'h0000);
      wait_valid(40, lat, low);
      check("rem latency", 32'(lat), 32'd16);
      check("rem result", 32'(s_res), 32'h0002);
      check("rem flags", 32'(s_flg), 32'h0100);
      sample();

      // Divide by zero
      issue(4'hD, 16'h00AB, 16'h0000, 16'h0000);
      check("div0 valid", 32'(s_valid), 32'd1);
      check("div0 result", 32'(s_res), 32'hFFFF);
      check("div0 flags", 32'(s_flg), 32'h0012);
      issue(4'hE, 16'h00AB, 16'h0000, 16'h0000);
      check("rem0 valid", 32'(s_valid), 32'd1);
      check("rem0 result", 32'(s_res), 32'h00AB);
      check("rem0 flags", 32'(s_flg), 32'h0010);

      // Shifts and copy
      issue(4'h6, 16'h8000, 16'h0004, 16'h0100);
      check("asr result", 32'(s_res), 32'hF800);
      check("asr flags", 32'(s_flg), 32'h0102);
      issue(4'h6, 16'h8000, 16'h0004, 16'h0000);
      check("lsr result", 32'(s_res), 32'h0800);
      issue(4'h6, 16'h8000, 16'h0014, 16'h0100);
      check("asr big result", 32'(s_res), 32'hFFFF);
      issue(4'h5, 16'h1234, 16'h0010, 16'h0000);
      check("shl big result", 32'(s_res), 32'h0000);
      check("shl big flags", 32'(s_flg), 32'h0001);
      issue(4'h5, 16'h1234, 16'h0004, 16'h0000);
      check("shl result", 32'(s_res), 32'h2340);
      issue(4'h0, 16'hFFFF, 16'h5A5A, 16'h0000);
      check("copy result", 32'(s_res), 32'h5A5A);
      check("copy write_flags", 32'(s_wf), 32'd0);

      // Reset in the middle of a multiply abandons it
      issue(4'hC, 16'h1234, 16'h0010, 16'h0000);
      repeat (3) sample();
      do_reset(1);
      check("midreset ready_out", 32'(s_ready), 32'd1);
      check("midreset valid_out", 32'(s_valid), 32'd0);
      check("midreset result_out", 32'(s_res), 32'h0000);
      repeat (20) sample();
      issue(4'hA, 16'h0002, 16'h0003, 16'h0000);
      check("post-reset add", 32'(s_res), 32'h0005);
      repeat (2) sample();
      check("expected results drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered successor to the combinational ALU.
- Single-cycle ops (bitwise, shift, byte, add/sub) produce a registered result one cycle after issue.
- Multiply, divide, remainder and multiply-high run on an iterative WIDTH-cycle shift engine behind a valid/ready handshake.
- Sits between the register-file read stage and write-back; the CPU stalls issue while ready_out is low.

Parameters:
- WIDTH, 16, data width of source, destination and result (must be >= 8 and even).
- FLAGS_W, 16, flags word width (must be >= 9).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- valid_in  input  1  op issue strobe; accepted when valid_in & ready_out.
- op_code  input  4  operation select.
- source  input  WIDTH  operand A.
- destination  input  WIDTH  operand B.
- flags  input  FLAGS_W  current flags; bit 8 = signed mode.
- ready_out  output  1  engine can accept an op.
- valid_out  output  1  one-cycle pulse when result_out/flags_out are valid.
- result_out  output  WIDTH  registered result.
- flags_out  output  FLAGS_W  registered updated flags.
- write_flags  output  1  qualified with valid_out; 1 for every op except 0.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; ready_out=1; valid_out=0; result_out=0; flags_out=0; write_flags=0.
  - Any in-flight iteration is abandoned with no valid_out.
- Operands, op_code and flags are captured at acceptance; inputs are don't-care afterwards.
- Op codes (D = destination, S = source):
  - 0 copy S.
  - 1 AND.
  - 2 OR.
  - 3 XOR.
  - 4 ~S.
  - 5 D<<S; S >= WIDTH gives 0.
  - 6 D>>S, arithmetic if flags[8] else logical; S >= WIDTH gives all sign bits (or 0).
  - 7 byte-half swap of S.
  - 8 high half of S, low half zeroed.
  - 9 low half of S, high half zeroed.
  - A D+S.
  - B D-S.
  - C low WIDTH bits of D*S.
  - D D/S quotient.
  - E D%S remainder.
  - F high WIDTH bits of D*S.
  - C–F are unsigned.
- Single-cycle ops (0–B):
  - Accepted at edge N: valid_out=1 in cycle N+1 for exactly one cycle.
  - ready_out stays 1, so back-to-back issue gives one result per cycle.
- Multi-cycle ops (C–F):
  - FSM states: IDLE, MUL, DIV, DONE.
  - Acceptance at edge N: ready_out=0 from N+1; counter loaded with WIDTH-1.
  - One partial product or one restoring-divide step per cycle.
  - Counter==0 → DONE; valid_out=1 in cycle N+1+WIDTH.
  - DONE → IDLE on the next edge; ready_out=1 again in cycle N+1+WIDTH.
  - Issue while ready_out=0 is ignored, with no side effect.
- Divide by zero (D or E with S==0):
  - No iteration; valid_out in cycle N+1.
  - Op D: result all ones. Op E: result = D.
  - divide_error=1.
- Flags (flags_out = flags with low 5 bits replaced; bits FLAGS_W-1..5 pass through from captured flags):
  - bit0 zero: result==0.
  - bit1 negative: result[WIDTH-1].
  - bit2 carry: A carry-out; B borrow (D<S); C/F high product nonzero; otherwise 0.
  - bit3 overflow: A/B signed overflow; otherwise 0.
  - bit4 divide_error: set only as above.
- result_out and flags_out hold their last value while valid_out=0.
- valid_out and a new acceptance may coincide in the DONE cycle only if ready_out=1; the new op's result follows with its own latency.

Test Plan:
- Reset mid-multiply: issue C 0x1234*0x0010, drop reset_n at cycle 5 → next cycle ready_out=1, valid_out=0, result_out=0; valid_out never pulses for that op.
- Back-to-back single-cycle: A 0xFFFF+0x0001 then B 0x0003-0x0005 on consecutive cycles →
  - first: result 0x0000, zero=1, carry=1, overflow=0;
  - second, next cycle: 0xFFFE, negative=1, carry=1.
- Multiply: C and F with D=0x1234, S=0x5678 →
  - valid_out 17 cycles after issue; results 0x0060 and 0x0626;
  - carry=1; ready_out low exactly 16 cycles.
- Divide/remainder: D=0x0064 with S=0x0007 →
  - op D gives 0x000E; op E gives 0x0002; both after 17 cycles;
  - valid_in pulses while busy are ignored.
- Divide by zero: op D, D=0x00AB, S=0 → result 0xFFFF, divide_error=1, valid_out next cycle; op E gives 0x00AB.
- Shifts:
  - op 6 D=0x8000, S=4, flags[8]=1 → 0xF800; with flags[8]=0 → 0x0800.
  - op 5 with S=16 → 0x0000, zero=1.
  - op 0 → write_flags=0.
